// File: rtl/ghost_pkg.sv
// rtl/ghost_pkg.sv - shared types and constants for the ghost array
package ghost_pkg;

    typedef enum logic [1:0] {
        G_ACTIVE = 2'd0,
        G_HIT    = 2'd1,
        G_DEAD   = 2'd2
    } ghost_state_t;

    localparam logic DIR_RIGHT = 1'b1;
    localparam logic DIR_LEFT  = 1'b0;

    // 12-bit {R,G,B}: red, pink, cyan, orange
    localparam logic [11:0] GHOST_PALETTE [4] = '{12'hF00, 12'hFBF, 12'h0FF, 12'hFB0};

    function automatic logic [11:0] ghost_colour(input int idx);
        logic [1:0] slot;
        slot = idx[1:0];
        return GHOST_PALETTE[slot];
    endfunction

endpackage

// File: rtl/ghost_mover.sv
// rtl/ghost_mover.sv - one ghost: horizontal mover plus hit/dead/respawn life-cycle
module ghost_mover
    import ghost_pkg::*;
#(
    parameter int unsigned SCREEN_W       = 640,
    parameter int unsigned SPRITE_W       = 32,
    parameter int unsigned STEP           = 2,
    parameter int unsigned SPAWN_X        = 64,
    parameter int unsigned SPAWN_Y        = 48,
    parameter logic        SPAWN_DIR      = DIR_RIGHT,
    parameter int unsigned HIT_FRAMES     = 8,
    parameter int unsigned RESPAWN_FRAMES = 60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        collision,
    output logic [31:0] x,
    output logic [31:0] y,
    output logic        visible,
    output logic        alive
);

    localparam logic [31:0] WALL_R     = 32'(SCREEN_W - SPRITE_W);
    localparam logic [31:0] STEP_V     = 32'(STEP);
    localparam logic [31:0] SPAWN_XV   = 32'(SPAWN_X);
    localparam logic [15:0] HIT_LOAD   = 16'(HIT_FRAMES - 1);
    localparam logic [15:0] RESP_LOAD  = 16'(RESPAWN_FRAMES - 1);

    ghost_state_t state, state_next;
    logic [31:0]  x_next;
    logic         dir, dir_next;
    logic         hit_latch, hit_latch_next;
    logic [15:0]  hit_cnt, hit_cnt_next;
    logic [15:0]  resp_cnt, resp_cnt_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= G_ACTIVE;
            x         <= SPAWN_XV;
            dir       <= SPAWN_DIR;
            hit_latch <= 1'b0;
            hit_cnt   <= '0;
            resp_cnt  <= '0;
        end else begin
            state     <= state_next;
            x         <= x_next;
            dir       <= dir_next;
            hit_latch <= hit_latch_next;
            hit_cnt   <= hit_cnt_next;
            resp_cnt  <= resp_cnt_next;
        end
    end

    always_comb begin
        state_next     = state;
        x_next         = x;
        dir_next       = dir;
        hit_latch_next = hit_latch;
        hit_cnt_next   = hit_cnt;
        resp_cnt_next  = resp_cnt;

        case (state)
            G_ACTIVE: begin
                // A collision coincident with the tick still counts as a hit on that tick
                if (frame_tick) begin
                    if (hit_latch || collision) begin
                        state_next     = G_HIT;
                        hit_cnt_next   = HIT_LOAD;
                        hit_latch_next = 1'b0;
                    end else if (dir == DIR_RIGHT) begin
                        if (x + STEP_V >= WALL_R) begin
                            x_next   = WALL_R;
                            dir_next = DIR_LEFT;
                        end else begin
                            x_next = x + STEP_V;
                        end
                    end else begin
                        if (x <= STEP_V) begin
                            x_next   = '0;
                            dir_next = DIR_RIGHT;
                        end else begin
                            x_next = x - STEP_V;
                        end
                    end
                end else if (collision) begin
                    hit_latch_next = 1'b1;
                end
            end
            G_HIT: begin
                hit_latch_next = 1'b0;
                if (frame_tick) begin
                    if (hit_cnt == '0) begin
                        state_next    = G_DEAD;
                        resp_cnt_next = RESP_LOAD;
                    end else begin
                        hit_cnt_next = hit_cnt - 16'd1;
                    end
                end
            end
            G_DEAD: begin
                hit_latch_next = 1'b0;
                if (frame_tick) begin
                    if (resp_cnt == '0) begin
                        state_next = G_ACTIVE;
                        x_next     = SPAWN_XV;
                        dir_next   = SPAWN_DIR;
                    end else begin
                        resp_cnt_next = resp_cnt - 16'd1;
                    end
                end
            end
            default: begin
                state_next     = G_ACTIVE;
                x_next         = SPAWN_XV;
                dir_next       = SPAWN_DIR;
                hit_latch_next = 1'b0;
            end
        endcase
    end

    assign y       = 32'(SPAWN_Y);
    assign alive   = (state == G_ACTIVE);
    // Blink while hit: odd counts are dark, so the first HIT frame is invisible
    assign visible = (state == G_ACTIVE) || ((state == G_HIT) && !hit_cnt[0]);

endmodule

// File: rtl/ghost_array_unit.sv
// rtl/ghost_array_unit.sv - NUM_GHOSTS movers merged into one registered RGB/Draw stream
module ghost_array_unit
    import ghost_pkg::*;
#(
    parameter int unsigned NUM_GHOSTS     = 4,
    parameter int unsigned SPRITE_W       = 32,
    parameter int unsigned SPRITE_H       = 32,
    parameter int unsigned SCREEN_W       = 640,
    parameter int unsigned STEP           = 2,
    parameter int unsigned X0             = 64,
    parameter int unsigned X_PITCH        = 128,
    parameter int unsigned Y0             = 48,
    parameter int unsigned ROW_PITCH      = 64,
    parameter int unsigned HIT_FRAMES     = 8,
    parameter int unsigned RESPAWN_FRAMES = 60
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_tick,
    input  logic [NUM_GHOSTS-1:0] collision,
    input  logic [31:0]           pxl_x,
    input  logic [31:0]           pxl_y,
    output logic [3:0]            Red,
    output logic [3:0]            Green,
    output logic [3:0]            Blue,
    output logic                  Draw,
    output logic [NUM_GHOSTS-1:0] alive
);

    localparam logic [31:0] SPR_W = 32'(SPRITE_W);
    localparam logic [31:0] SPR_H = 32'(SPRITE_H);

    logic [31:0]           gx [NUM_GHOSTS];
    logic [31:0]           gy [NUM_GHOSTS];
    logic [NUM_GHOSTS-1:0] vis;
    logic [NUM_GHOSTS-1:0] hit;

    generate
        for (genvar i = 0; i < int'(NUM_GHOSTS); i++) begin : g_ghost
            ghost_mover #(
                .SCREEN_W       (SCREEN_W),
                .SPRITE_W       (SPRITE_W),
                .STEP           (STEP),
                .SPAWN_X        (X0 + i * X_PITCH),
                .SPAWN_Y        (Y0 + i * ROW_PITCH),
                .SPAWN_DIR      ((i % 2 == 0) ? DIR_RIGHT : DIR_LEFT),
                .HIT_FRAMES     (HIT_FRAMES),
                .RESPAWN_FRAMES (RESPAWN_FRAMES)
            ) u_mover (
                .clk        (clk),
                .reset      (reset),
                .frame_tick (frame_tick),
                .collision  (collision[i]),
                .x          (gx[i]),
                .y          (gy[i]),
                .visible    (vis[i]),
                .alive      (alive[i])
            );

            assign hit[i] = vis[i]
                         && (pxl_x >= gx[i]) && (pxl_x < gx[i] + SPR_W)
                         && (pxl_y >= gy[i]) && (pxl_y < gy[i] + SPR_H);
        end
    endgenerate

    logic        win_draw;
    logic [11:0] win_rgb;

    // Scan from the top index down so the lowest-index hitting ghost is written last and wins
    always_comb begin
        win_draw = 1'b0;
        win_rgb  = '0;
        for (int i = int'(NUM_GHOSTS) - 1; i >= 0; i--) begin
            if (hit[i]) begin
                win_draw = 1'b1;
                win_rgb  = ghost_colour(i);
            end
        end
    end

    logic        draw_q;
    logic [11:0] rgb_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            draw_q <= 1'b0;
            rgb_q  <= '0;
        end else begin
            draw_q <= win_draw;
            rgb_q  <= win_rgb;
        end
    end

    assign Draw  = draw_q;
    assign Red   = rgb_q[11:8];
    assign Green = rgb_q[7:4];
    assign Blue  = rgb_q[3:0];

endmodule

// File: tb/tb_ghost_array_unit.sv
// tb/tb_ghost_array_unit.sv - scoreboard bench for ghost_array_unit (default and overlapping layouts)
module tb_ghost_array_unit;

    localparam logic [11:0] PAL0 = 12'hF00;
    localparam logic [11:0] PAL1 = 12'hFBF;
    localparam logic [11:0] PAL2 = 12'h0FF;
    localparam logic [11:0] PAL3 = 12'hFB0;
    localparam logic [11:0] NONE = 12'h000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_tick = 1'b0;
    logic [3:0]  coll_a = '0;
    logic [3:0]  coll_b = '0;
    logic [31:0] pxl_x = '0;
    logic [31:0] pxl_y = '0;

    logic [3:0] red_a, green_a, blue_a, alive_a;
    logic [3:0] red_b, green_b, blue_b, alive_b;
    logic       draw_a, draw_b;

    always #5 clk = ~clk;

    ghost_array_unit dut_a (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .collision(coll_a),
        .pxl_x(pxl_x), .pxl_y(pxl_y),
        .Red(red_a), .Green(green_a), .Blue(blue_a), .Draw(draw_a), .alive(alive_a)
    );

    ghost_array_unit #(.X_PITCH(16), .ROW_PITCH(0)) dut_b (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .collision(coll_b),
        .pxl_x(pxl_x), .pxl_y(pxl_y),
        .Red(red_b), .Green(green_b), .Blue(blue_b), .Draw(draw_b), .alive(alive_b)
    );

    int total = 0;
    int bad = 0;

    logic [16:0] exp_q [$];
    string       name_q [$];
    bit          sel_q [$];

    logic probe_req = 1'b0;
    logic pv_d = 1'b0;

    always @(posedge clk) pv_d <= probe_req;

    task automatic cmp(input string n, input string f, input logic [11:0] act, input logic [11:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s.%s actual=%0h required=%0h", n, f, act, req);
        end
    endtask

    logic [16:0] m_exp;
    string       m_name;
    bit          m_sel;
    logic        m_draw;
    logic [11:0] m_rgb;
    logic [3:0]  m_alive;

    always @(negedge clk) begin
        if (pv_d) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL scoreboard_underflow actual=output required=expected_entry");
            end else begin
                m_exp   = exp_q.pop_front();
                m_name  = name_q.pop_front();
                m_sel   = sel_q.pop_front();
                m_draw  = m_sel ? draw_b : draw_a;
                m_rgb   = m_sel ? {red_b, green_b, blue_b} : {red_a, green_a, blue_a};
                m_alive = m_sel ? alive_b : alive_a;
                cmp(m_name, "draw", 12'(m_draw), 12'(m_exp[16]));
                cmp(m_name, "rgb", m_rgb, m_exp[15:4]);
                cmp(m_name, "alive", 12'(m_alive), 12'(m_exp[3:0]));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic probe(input bit sel, input int x, input int y, input bit d,
                         input logic [11:0] rgb, input logic [3:0] al, input string n);
        pxl_x = 32'(x);
        pxl_y = 32'(y);
        probe_req = 1'b1;
        exp_q.push_back({d, rgb, al});
        name_q.push_back(n);
        sel_q.push_back(sel);
        cyc();
        probe_req = 1'b0;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        cyc();
        // reset state on both instances
        probe(0, 64, 48, 0, NONE, 4'b1111, "rst_a");
        probe(1, 64, 48, 0, NONE, 4'b1111, "rst_b");
        reset = 1'b0;

        // bounding box of ghost0 at (64,48)
        probe(0, 64, 48, 1, PAL0, 4'b1111, "t1_corner");
        probe(0, 63, 48, 0, NONE, 4'b1111, "t1_left_out");
        probe(0, 96, 48, 0, NONE, 4'b1111, "t1_right_out");
        probe(0, 95, 79, 1, PAL0, 4'b1111, "t1_far_corner");
        probe(0, 95, 80, 0, NONE, 4'b1111, "t1_bottom_out");
        probe(0, 192, 112, 1, PAL1, 4'b1111, "t1_ghost1");

        // collision coincident with tick: ghost2 hit, frozen at 320
        coll_a = 4'b0100;
        tick();
        coll_a = '0;
        probe(0, 320, 176, 0, NONE, 4'b1011, "t4_hit_dark");
        tick();
        probe(0, 320, 176, 1, PAL2, 4'b1011, "t4_x_left");
        probe(0, 319, 176, 0, NONE, 4'b1011, "t4_x_left_out");
        probe(0, 351, 207, 1, PAL2, 4'b1011, "t4_x_right");
        probe(0, 352, 176, 0, NONE, 4'b1011, "t4_x_right_out");
        probe(0, 320, 208, 0, NONE, 4'b1011, "t4_y_out");

        // hit / blink / dead / respawn of ghost1
        do_reset();
        coll_a = 4'b0010;
        cyc();
        coll_a = '0;
        probe(0, 192, 112, 1, PAL1, 4'b1111, "t3_latched_no_tick");
        tick();
        probe(0, 192, 112, 0, NONE, 4'b1101, "t3_hit1");
        for (int k = 2; k <= 8; k++) begin
            if (k == 3) begin
                coll_a = 4'b0010;
                cyc();
                coll_a = '0;
            end
            tick();
            probe(0, 192, 112, (k % 2 == 0), (k % 2 == 0) ? PAL1 : NONE, 4'b1101, $sformatf("t3_blink%0d", k));
        end
        tick();
        probe(0, 192, 112, 0, NONE, 4'b1101, "t3_dead_first");
        ticks(30);
        coll_a = 4'b0010;
        cyc();
        coll_a = '0;
        ticks(29);
        probe(0, 192, 112, 0, NONE, 4'b1101, "t3_dead_last");
        tick();
        probe(0, 192, 112, 1, PAL1, 4'b1111, "t3_respawn");
        tick();
        probe(0, 190, 112, 1, PAL1, 4'b1111, "t3_moves_left");
        probe(0, 222, 112, 0, NONE, 4'b1111, "t3_moves_left_out");

        // walls on ghost0
        do_reset();
        ticks(271);
        probe(0, 606, 48, 1, PAL0, 4'b1111, "t2_pre_wall");
        probe(0, 605, 48, 0, NONE, 4'b1111, "t2_pre_wall_out");
        tick();
        probe(0, 608, 48, 1, PAL0, 4'b1111, "t2_right_wall");
        probe(0, 639, 48, 1, PAL0, 4'b1111, "t2_right_edge");
        probe(0, 607, 48, 0, NONE, 4'b1111, "t2_right_wall_out");
        tick();
        probe(0, 606, 48, 1, PAL0, 4'b1111, "t2_turned_left");
        probe(0, 638, 48, 0, NONE, 4'b1111, "t2_turned_left_out");
        ticks(302);
        probe(0, 2, 48, 1, PAL0, 4'b1111, "t2_pre_left");
        probe(0, 1, 48, 0, NONE, 4'b1111, "t2_pre_left_out");
        tick();
        probe(0, 0, 48, 1, PAL0, 4'b1111, "t2_left_wall");
        probe(0, 32, 48, 0, NONE, 4'b1111, "t2_left_wall_out");
        tick();
        probe(0, 1, 48, 0, NONE, 4'b1111, "t2_turned_right_out");
        probe(0, 2, 48, 1, PAL0, 4'b1111, "t2_turned_right");

        // overlapping ghosts on the second instance
        do_reset();
        probe(1, 85, 50, 1, PAL0, 4'b1111, "t5_overlap");
        coll_b = 4'b0001;
        cyc();
        coll_b = '0;
        tick();
        probe(1, 85, 50, 1, PAL1, 4'b1110, "t5_g0_dark");
        tick();
        probe(1, 85, 50, 1, PAL0, 4'b1110, "t5_g0_blink");
        ticks(7);
        probe(1, 85, 50, 1, PAL1, 4'b1110, "t5_g0_dead");

        // reset beats frame_tick while ghost3 is dead
        do_reset();
        coll_a = 4'b1000;
        cyc();
        coll_a = '0;
        ticks(9);
        probe(0, 0, 0, 0, NONE, 4'b0111, "t6_g3_dead");
        reset = 1'b1;
        frame_tick = 1'b1;
        probe(0, 64, 48, 0, NONE, 4'b1111, "t6_reset_over_tick");
        reset = 1'b0;
        frame_tick = 1'b0;
        probe(0, 448, 240, 1, PAL3, 4'b1111, "t6_g3_spawn");
        probe(0, 64, 48, 1, PAL0, 4'b1111, "t6_g0_spawn");

        cyc();
        cyc();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
